// File: rtl/hamming_tx_ser.sv
// hamming_tx_ser: Hamming(15,11) encoder with LSB-first serial transmitter
// Ports: clk/RST (async active-low) | data_in[10:0], in_valid, in_ready: word handshake
//        shift: bit-advance enable | sl_out: serial bit | frame_start: bit 0 on sl_out
//        busy: SEND or GAP | done: one-cycle pulse after the last bit is consumed
// Option: HAMMING_TX_PARITY_EN appends an overall even-parity bit (16-bit frame)
module hamming_tx_ser #(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [10:0] data_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        shift,
  output logic        sl_out,
  output logic        frame_start,
  output logic        busy,
  output logic        done
);
`ifdef HAMMING_TX_PARITY_EN
  localparam int FRAME_LEN = 16;
`else
  localparam int FRAME_LEN = 15;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [FRAME_LEN-1:0] sr_q, sr_d, cw;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] gap_q, gap_d;
  logic done_q, done_d;
  logic [14:0] c;
  logic p1, p2, p4, p8;
  // parity k covers every data position whose index has bit k set
  assign p1 = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6] ^ data_in[8] ^ data_in[10];
  assign p2 = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6] ^ data_in[9] ^ data_in[10];
  assign p4 = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7] ^ data_in[8] ^ data_in[9] ^ data_in[10];
  assign p8 = ^data_in[10:4];
  assign c = {data_in[10:4], p8, data_in[3:1], p4, data_in[0], p2, p1};
`ifdef HAMMING_TX_PARITY_EN
  assign cw = {^c, c};
`else
  assign cw = c;
`endif
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = SEND;
        sr_d    = cw;
        cnt_d   = '0;
      end
      SEND: if (shift) begin
        sr_d  = {1'b0, sr_q[FRAME_LEN-1:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_BIT) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign sl_out      = (state_q == SEND) & sr_q[0];
  assign frame_start = (state_q == SEND) && (cnt_q == '0);
  assign done        = done_q;
endmodule

// File: tb/tb_hamming_tx_ser.sv
// tb_hamming_tx_ser: scoreboard bench for hamming_tx_ser (GAP_CYCLES=3)
module tb_hamming_tx_ser;
`ifdef HAMMING_TX_PARITY_EN
  localparam int FL = 16;
`else
  localparam int FL = 15;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [10:0] data_in = '0;
  logic in_valid = 1'b0;
  logic in_ready, shift = 1'b0, sl_out, frame_start, busy, done;
  int n_vec = 0, n_fail = 0, cyc = 0;
  logic exp_q[$];
  int acc_q[$];
  bit infr = 0, done_exp = 0;
  int nb = 0;
  hamming_tx_ser #(.GAP_CYCLES(3)) dut (
    .clk(clk), .RST(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .shift(shift), .sl_out(sl_out), .frame_start(frame_start), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
  always @(negedge clk) begin
    if (!rst_n) begin
      infr = 0;
      nb = 0;
      done_exp = 0;
    end else begin
      if (done_exp) begin
        chk1("done_pulse", done, 1'b1);
        done_exp = 0;
      end else if (infr) chk1("done_low", done, 1'b0);
      if (!infr && frame_start) begin
        infr = 1;
        nb = 0;
      end
      if (infr) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_bit at cycle %0d: got %b expected none", cyc, sl_out);
          infr = 0;
        end else begin
          chk1("sl_out", sl_out, exp_q[0]);
          chk1("frame_start", frame_start, nb == 0);
          chk1("busy", busy, 1'b1);
          if (shift) begin
            void'(exp_q.pop_front());
            nb++;
            if (nb == FL) begin
              infr = 0;
              done_exp = 1;
            end
          end
        end
      end
    end
  end
  task automatic push_cw(input logic [14:0] cw, input logic par);
    for (int i = 0; i < 15; i++) exp_q.push_back(cw[i]);
    if (FL == 16) exp_q.push_back(par);
  endtask
  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk1("ready_wait", in_ready, 1'b1);
  endtask
  task automatic wait_done(input bit stall);
    int t = 0;
    while (!done && t < 200) begin
      shift = stall ? (t % 3 == 0) : 1'b1;
      @(posedge clk); #1;
      t++;
    end
    shift = 1'b1;
    chk1("frame_end", done, 1'b1);
  endtask
  task automatic send(input logic [10:0] d, input logic [14:0] cw, input logic par, input bit stall);
    wait_ready();
    push_cw(cw, par);
    data_in = d;
    in_valid = 1'b1;
    shift = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in = ~d;
    wait_done(stall);
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk1({nm, "_in_ready"}, in_ready, 1'b1);
    chk1({nm, "_sl_out"}, sl_out, 1'b0);
    chk1({nm, "_frame_start"}, frame_start, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_done"}, done, 1'b0);
  endtask
  initial begin
    #3;
    chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("idle");
    send(11'h000, 15'h0000, 1'b0, 0);
    send(11'h7FF, 15'h7FFF, 1'b1, 0);
    send(11'h001, 15'h0007, 1'b1, 0);
    send(11'h001, 15'h0007, 1'b1, 1);
    send(11'h002, 15'h0019, 1'b1, 0);
    send(11'h400, 15'h408B, 1'b1, 0);
    send(11'h003, 15'h001E, 1'b0, 1);
    send(11'h010, 15'h0181, 1'b1, 0);
    wait_ready();
    acc_q.delete();
    push_cw(15'h7FFF, 1'b1);
    data_in = 11'h7FF;
    in_valid = 1'b1;
    shift = 1'b1;
    @(posedge clk); #1;
    data_in = 11'h002;
    push_cw(15'h0019, 1'b1);
    for (int t = 0; t < 100 && acc_q.size() < 2; t++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(0);
    n_vec++;
    if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != FL + 4) begin
      n_fail++;
      $display("FAIL accept_spacing: got %0d accepts spaced %0d expected 2 spaced %0d",
               acc_q.size(), (acc_q.size() >= 2) ? acc_q[1] - acc_q[0] : -1, FL + 4);
    end
    wait_ready();
    push_cw(15'h7FFF, 1'b1);
    data_in = 11'h7FF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk1("pre_reset_bit7", sl_out, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("async");
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("post_reset_ready", in_ready, 1'b1);
    send(11'h001, 15'h0007, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_bits: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hamming_tx_ser.md
# hamming_tx_ser

Hamming(15,11) encoder and serial transmitter. It accepts an 11-bit data word over a valid/ready handshake, computes the four Hamming parity bits, and shifts the 15-bit codeword out LSB-first on `sl_out`, gated by `shift`. It is the transmit-side counterpart of the serial-in Hamming decoder path, and feeds that path's `sl_in` directly, with the same bit order and the same `shift` stall semantics.

## Interface
Parameters:
- `GAP_CYCLES`, default 0: idle cycles forced after each frame before `in_ready` reasserts (0–255).

Ports:
- `clk` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `data_in` in 11: data word d[10:0]; sampled on accept.
- `in_valid` in 1: `data_in` valid.
- `in_ready` out 1: block can accept a word.
- `shift` in 1: bit-advance enable; 0 stalls the frame with `sl_out` held.
- `sl_out` out 1: serial codeword bit.
- `frame_start` out 1: high while bit 0 of a frame is on `sl_out`.
- `busy` out 1: frame in progress (SEND or GAP).
- `done` out 1: one-cycle pulse after the last bit is consumed.

## Operation
- Codeword c[14:0]: c[i] holds Hamming position i+1.
  - Parity bits sit at positions 1, 2, 4 and 8.
  - d0..d10 go in ascending order into positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15.
  - p1 = XOR of data positions with bit0 of the position set; p2 uses bit1; p4 uses bit2; p8 uses bit3.
- Encoding is combinational from `data_in`. The codeword is registered into the shift register on accept.
- FSM states and transitions:
  - IDLE: `in_ready`=1. `in_valid` high causes an accept: load the shift register, clear the bit counter, go to SEND.
  - SEND: `sl_out` = shift register bit 0.
    - Each edge with `shift`=1 shifts right (zero-fill) and increments the bit counter.
    - The edge that consumes bit FRAME_LEN-1 goes to GAP if GAP_CYCLES>0, otherwise to IDLE. `done` is set on that edge.
  - GAP: counts GAP_CYCLES clocks regardless of `shift`, then goes to IDLE.
- `in_ready` = (state==IDLE), combinational from state only; it never depends on `in_valid`.
- `in_valid` in SEND or GAP is ignored; `data_in` is not captured.
- `sl_out` = 0 in IDLE and GAP.
- `frame_start` = (state==SEND && bit counter==0).
- Bit counter is 4 bits, range 0..FRAME_LEN-1; no wrap within a frame. FRAME_LEN = 15, or 16 (see Configuration).
- The gap counter is 8 bits.
- Reset (any time, including mid-frame): the frame is abandoned and the FSM returns to IDLE immediately.

## Timing
- Reset values: `in_ready`=1, `sl_out`=0, `frame_start`=0, `busy`=0, `done`=0; shift register, counters and FSM at 0/IDLE.
- Accept at edge k: from edge k onward `sl_out`=c[0], `frame_start`=1, `busy`=1, `in_ready`=0.
- With `shift` held 1: c[n] is on `sl_out` in the cycle after edge k+n.
  - The last bit is consumed at edge k+FRAME_LEN.
  - `done` is high for the single cycle after that edge.
- Minimum accept-to-accept spacing is FRAME_LEN+1+GAP_CYCLES clocks; there is at least one IDLE cycle between frames.
- `shift`=0 in SEND freezes the shift register, bit counter and `sl_out`; it adds no other latency.
- `shift` in IDLE or GAP has no effect.

## Configuration
- `HAMMING_TX_PARITY_EN` defined:
  - FRAME_LEN=16.
  - Bit 15 is the overall parity, i.e. XOR of c[14:0]. This gives even parity over all 16 bits (SECDED).
  - It is sent last.
- Undefined: FRAME_LEN=15; no extra bit and no parity logic.

## Test plan
- Reset, then `data_in`=11'h000 accepted with `shift`=1 → 15 zeros on `sl_out`; `frame_start` only on the first bit; `done` one cycle after the 15th bit (16 bits, last 0, with `HAMMING_TX_PARITY_EN`).
- `data_in`=11'h7FF → codeword 15'h7FFF, 15 ones; with the macro, bit 15 = 1.
- `data_in`=11'h001 → 15'h0007, serial 1,1,1 then 12 zeros; with the macro, bit 15 = 1.
- `data_in`=11'h001, `shift` toggled 1,0,0,1,... → `sl_out` holds during stalls; bit sequence unchanged; `done` delayed by the number of stall cycles.
- `GAP_CYCLES`=3, `in_valid` held high with two words → second accept exactly FRAME_LEN+4 clocks after the first; no capture while `busy`.
- `RST` asserted at bit 7 of a frame → all outputs reach reset values immediately, without waiting for a clock edge; after release, `in_ready`=1 and the next frame is clean from c[0].
